// File: rtl/lib_arb_pkg.sv
// Shared arbitration types and one-hot helpers for the LIB round-robin grant controller.
package lib_arb_pkg;

  localparam int MAX_N = 64;
  localparam int IDX_W = $clog2(MAX_N);

  typedef enum logic {IDLE, LOCKED} arb_state_t;

  // Rotate the low n bits of v left by one; bit n-1 wraps to bit 0.
  function automatic logic [MAX_N-1:0] rotl1(input logic [MAX_N-1:0] v, input int n);
    logic [MAX_N-1:0] r;
    r = '0;
    for (int i = 0; i < MAX_N - 1; i++)
      if (i < n - 1) r[i+1] = v[i];
    r[0] = v[n-1];
    return r;
  endfunction

  function automatic logic [IDX_W-1:0] onehot2bin(input logic [MAX_N-1:0] v);
    logic [IDX_W-1:0] b;
    b = '0;
    for (int i = 0; i < MAX_N; i++)
      if (v[i]) b = b | IDX_W'(i);
    return b;
  endfunction

endpackage

// File: rtl/lib_rr_grant_ctrl_if.sv
// Request/grant bundle between requesters (master) and the grant controller (slave).
interface lib_rr_grant_ctrl_if #(parameter int N = 16);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  logic [N-1:0]  i_request;
  logic [N-1:0]  i_release;
  logic [N-1:0]  o_grant;
  logic [IW-1:0] o_grant_idx;
  logic          o_anyGnt;
  logic [N-1:0]  o_priority;

  modport master (output i_request, i_release,
                  input  o_grant, o_grant_idx, o_anyGnt, o_priority);
  modport slave  (input  i_request, i_release,
                  output o_grant, o_grant_idx, o_anyGnt, o_priority);
endinterface

// File: rtl/lib_rr_grant_ctrl_ppe.sv
// Programmable priority encoder: first request at or above the one-hot priority, circular.
// Purely combinational; group carries give the look-ahead, LAH=0 is one plain ripple chain.
module lib_rr_grant_ctrl_ppe #(
  parameter int N   = 16,
  parameter int LAH = 4
) (
  input  logic [N-1:0] i_request,
  input  logic [N-1:0] i_priority,
  output logic [N-1:0] o_grant,
  output logic         o_any
);
  localparam int GS = (LAH == 0) ? N : LAH;
  localparam int NG = N / GS;

  if ((N % GS) != 0) begin : g_bad_lah
    $error("lib_rr_grant_ctrl_ppe: N must be a multiple of LAH");
  end

  logic [NG-1:0] gen, prop, cin;

  // The search token starts at the priority bit and runs upward until it hits a request.
  // Two passes over the group chain close the circular wrap without a combinational loop.
  always_comb begin
    logic c, s;
    gen     = '0;
    prop    = '0;
    cin     = '0;
    o_grant = '0;
    c       = 1'b0;
    s       = 1'b0;
    for (int k = 0; k < NG; k++) begin
      c = 1'b0;
      for (int j = 0; j < GS; j++) begin
        s = i_priority[k*GS+j] | c;
        c = s & ~i_request[k*GS+j];
      end
      gen[k]  = c;
      prop[k] = ~|i_request[k*GS +: GS];
    end
    c = 1'b0;
    for (int k = 0; k < NG; k++) c = gen[k] | (prop[k] & c);
    for (int k = 0; k < NG; k++) begin
      cin[k] = c;
      c      = gen[k] | (prop[k] & c);
    end
    for (int k = 0; k < NG; k++) begin
      c = cin[k];
      for (int j = 0; j < GS; j++) begin
        s               = i_priority[k*GS+j] | c;
        o_grant[k*GS+j] = i_request[k*GS+j] & s;
        c               = s & ~i_request[k*GS+j];
      end
    end
  end

  assign o_any = |o_grant;

endmodule

// File: rtl/lib_rr_grant_ctrl.sv
// Round-robin grant controller: owns the rotating pointer, locks the grant until release,
// and hands over with no bubble when another requester is waiting.
module lib_rr_grant_ctrl
  import lib_arb_pkg::*;
#(
  parameter int N   = 16,
  parameter int LAH = 4
) (
  input  logic                i_clk,
  input  logic                i_reset_n,
  lib_rr_grant_ctrl_if.slave  bus
);
  localparam int IW = (N > 1) ? $clog2(N) : 1;

  if (N > MAX_N) begin : g_bad_n
    $error("lib_rr_grant_ctrl: N exceeds MAX_N");
  end

  arb_state_t    state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [N-1:0]  ptr_q, ptr_d;
  logic [IW-1:0] idx_q, idx_d;
  logic          any_q;

  logic [N-1:0]     ptr_next, ppe_pri, ppe_gnt;
  logic [MAX_N-1:0] rot_full;
  logic [IDX_W-1:0] idx_full;
  logic             ppe_any, rel_evt;

  assign rot_full = rotl1(MAX_N'(grant_q), N);
  assign ptr_next = rot_full[N-1:0];
  assign ppe_pri  = (state_q == LOCKED) ? ptr_next : ptr_q;

  // A dropped request counts as an implicit release; releases of non-holders never match.
  assign rel_evt = (state_q == LOCKED) &&
                   ((|(grant_q & bus.i_release)) || !(|(grant_q & bus.i_request)));

  lib_rr_grant_ctrl_ppe #(.N(N), .LAH(LAH)) u_ppe (
    .i_request  (bus.i_request),
    .i_priority (ppe_pri),
    .o_grant    (ppe_gnt),
    .o_any      (ppe_any)
  );

  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    ptr_d   = ptr_q;
    case (state_q)
      IDLE: begin
        if (ppe_any) begin
          grant_d = ppe_gnt;
          state_d = LOCKED;
        end
      end
      LOCKED: begin
        if (rel_evt) begin
          ptr_d   = ptr_next;
          grant_d = ppe_gnt;
          state_d = ppe_any ? LOCKED : IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign idx_full = onehot2bin(MAX_N'(grant_d));
  assign idx_d    = idx_full[IW-1:0];

  always_ff @(posedge i_clk or negedge i_reset_n) begin
    if (!i_reset_n) begin
      state_q <= IDLE;
      grant_q <= '0;
      ptr_q   <= N'(1);
      idx_q   <= '0;
      any_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      ptr_q   <= ptr_d;
      idx_q   <= idx_d;
      any_q   <= |grant_d;
    end
  end

  assign bus.o_grant     = grant_q;
  assign bus.o_grant_idx = idx_q;
  assign bus.o_anyGnt    = any_q;
  assign bus.o_priority  = ptr_q;

endmodule

// File: tb/tb_lib_rr_grant_ctrl.sv
// Directed vector bench for lib_rr_grant_ctrl at N=4, LAH=2.
module tb_lib_rr_grant_ctrl;
  localparam int N  = 4;
  localparam int IW = 2;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  lib_rr_grant_ctrl_if #(.N(N)) bus ();

  lib_rr_grant_ctrl #(.N(N), .LAH(2)) dut (
    .i_clk     (clk),
    .i_reset_n (rst_n),
    .bus       (bus)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [N-1:0]  req;
    logic [N-1:0]  rel;
    logic [N-1:0]  gnt;
    logic [IW-1:0] idx;
    logic          any;
    logic [N-1:0]  pri;
  } vec_t;

  vec_t vecs [23];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [N-1:0] gnt, input logic [IW-1:0] idx,
                         input logic any, input logic [N-1:0] pri);
    chk({tag, " grant"}, 32'(bus.o_grant), 32'(gnt));
    chk({tag, " idx"},   32'(bus.o_grant_idx), 32'(idx));
    chk({tag, " any"},   32'(bus.o_anyGnt), 32'(any));
    chk({tag, " prio"},  32'(bus.o_priority), 32'(pri));
  endtask

  // Inputs change on the falling edge; outputs are sampled on the next falling edge.
  task automatic step(input logic [N-1:0] req, input logic [N-1:0] rel);
    bus.i_request = req;
    bus.i_release = rel;
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    //               req      rel      gnt      idx  any  pri
    vecs[0]  = '{4'b1111, 4'b0001, 4'b0010, 2'd1, 1'b1, 4'b0010};
    vecs[1]  = '{4'b1111, 4'b0010, 4'b0100, 2'd2, 1'b1, 4'b0100};
    vecs[2]  = '{4'b1111, 4'b0100, 4'b1000, 2'd3, 1'b1, 4'b1000};
    vecs[3]  = '{4'b1111, 4'b1000, 4'b0001, 2'd0, 1'b1, 4'b0001};
    vecs[4]  = '{4'b0010, 4'b0001, 4'b0010, 2'd1, 1'b1, 4'b0010};
    vecs[5]  = '{4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b1, 4'b0010};
    vecs[6]  = '{4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b1, 4'b0010};
    vecs[7]  = '{4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b1, 4'b0010};
    vecs[8]  = '{4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b1, 4'b0010};
    vecs[9]  = '{4'b1111, 4'b0000, 4'b0010, 2'd1, 1'b1, 4'b0010};
    vecs[10] = '{4'b1111, 4'b1101, 4'b0010, 2'd1, 1'b1, 4'b0010};
    vecs[11] = '{4'b1000, 4'b0010, 4'b1000, 2'd3, 1'b1, 4'b0100};
    vecs[12] = '{4'b1000, 4'b1000, 4'b1000, 2'd3, 1'b1, 4'b0001};
    vecs[13] = '{4'b0000, 4'b0000, 4'b0000, 2'd0, 1'b0, 4'b0001};
    vecs[14] = '{4'b0000, 4'b1111, 4'b0000, 2'd0, 1'b0, 4'b0001};
    vecs[15] = '{4'b0100, 4'b0000, 4'b0100, 2'd2, 1'b1, 4'b0001};
    vecs[16] = '{4'b0101, 4'b0010, 4'b0100, 2'd2, 1'b1, 4'b0001};
    vecs[17] = '{4'b0001, 4'b0000, 4'b0001, 2'd0, 1'b1, 4'b1000};
    vecs[18] = '{4'b0011, 4'b0001, 4'b0010, 2'd1, 1'b1, 4'b0010};
    vecs[19] = '{4'b0011, 4'b0000, 4'b0010, 2'd1, 1'b1, 4'b0010};
    vecs[20] = '{4'b0000, 4'b0010, 4'b0000, 2'd0, 1'b0, 4'b0100};
    vecs[21] = '{4'b0011, 4'b0000, 4'b0001, 2'd0, 1'b1, 4'b0100};
    vecs[22] = '{4'b0011, 4'b0001, 4'b0010, 2'd1, 1'b1, 4'b0010};

    rst_n         = 1'b0;
    bus.i_request = 4'b1111;
    bus.i_release = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    chk_all("reset", 4'b0000, 2'd0, 1'b0, 4'b0001);

    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_all("first grant", 4'b0001, 2'd0, 1'b1, 4'b0001);

    for (int i = 0; i < 23; i++) begin
      step(vecs[i].req, vecs[i].rel);
      chk_all($sformatf("vec%0d", i), vecs[i].gnt, vecs[i].idx, vecs[i].any, vecs[i].pri);
    end

    // Hand over to requester 2, then reset in the middle of the locked transfer.
    step(4'b0100, 4'b0010);
    chk_all("lock on 2", 4'b0100, 2'd2, 1'b1, 4'b0100);
    #2 rst_n = 1'b0;
    #1 chk_all("async reset", 4'b0000, 2'd0, 1'b0, 4'b0001);
    @(negedge clk);
    bus.i_request = 4'b0000;
    rst_n         = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_all("post reset idle", 4'b0000, 2'd0, 1'b0, 4'b0001);
    step(4'b1100, 4'b0000);
    chk_all("post reset grant", 4'b0100, 2'd2, 1'b1, 4'b0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lib_rr_grant_ctrl.md
# lib_rr_grant_ctrl

Sequential round-robin grant controller for the programmable priority encoder (PPE) in LIB. It is the requester-facing end of the request/grant interface:
- owns the rotating one-hot priority pointer that feeds the PPE;
- registers and locks the winning grant for a multi-cycle transfer;
- advances fairness on release.

Sits in front of each switch output port or crossbar column.

## Interface
Parameters:
- N, 16, number of requesters; N % LAH == 0 required (elaboration error otherwise).
- LAH, 4, carry look-ahead group size passed to the PPE sub-module; 0 selects the plain ripple encoder.

Ports:
- i_clk  in  1  single clock, rising-edge.
- i_reset_n  in  1  asynchronous, active-low reset.
- i_request  in  N  per-requester request vector; level-sensitive.
- i_release  in  N  per-requester end-of-transfer pulse; only the bit of the current grant holder is honoured.
- o_grant  out  N  registered one-hot grant; all-zero when idle.
- o_grant_idx  out  $clog2(N)  binary index of the o_grant bit; 0 when idle.
- o_anyGnt  out  1  registered; high exactly when o_grant != 0.
- o_priority  out  N  current one-hot priority pointer, for debug and monitoring.

## Operation
- State machine: IDLE, LOCKED.
- IDLE:
  - each cycle, the PPE evaluates i_request against o_priority;
  - if any request is present, register the PPE grant and go to LOCKED; otherwise stay in IDLE.
- LOCKED:
  - o_grant is held constant;
  - requests from other requesters are ignored;
  - the pointer is unchanged.
- Release event: i_release[g] high, or i_request[g] low, where g is the granted index. A dropped request is treated as an implicit release.
- On a release event, in the same cycle:
  - pointer_next = rotate-left-by-1 of o_grant (bit N-1 wraps to bit 0);
  - the PPE is re-evaluated with i_request and pointer_next;
  - the released requester's bit is masked off if its request is low.
- Result of re-evaluation:
  - grant present: load the new grant and stay in LOCKED (zero-bubble hand-over);
  - no grant: clear o_grant and go to IDLE.
- The released requester has the lowest priority on re-arbitration. It regains the grant immediately only if it is the sole requester.
- i_release bits for non-holders, and any i_release while in IDLE, are ignored.
- The pointer changes only on a release event. Granting from IDLE does not move it.

## Timing
- Reset, asynchronous:
  - o_grant = 0, o_grant_idx = 0, o_anyGnt = 0;
  - o_priority = 1 (bit 0 highest);
  - state = IDLE.
- Reset takes effect mid-transfer with no release side-effects.
- Grant latency from IDLE: request high in cycle t gives o_grant valid from cycle t+1.
- Hand-over latency: release in cycle t gives the new grant (or 0) in cycle t+1, with the pointer updated at the same edge.
- Minimum grant duration: 1 cycle. A release may be asserted in the first LOCKED cycle.
- Simultaneous requests: the winner is the first requesting index at or above the pointer position, with circular wrap-around, as resolved by the PPE.
- Request and release of the same holder in the same cycle: this is a release. The holder may re-win only if no other request is present.
- The path through the PPE is combinational from i_request and i_release to the grant register D input. There is no combinational path to any output.

## Structure
- Shared package lib_arb_pkg:
  - function rotl1 (one-hot rotate-left by one over N bits);
  - function onehot2bin;
  - typedef enum {IDLE, LOCKED} arb_state_t.
- One sub-module: the existing LIB programmable priority encoder with look-ahead.
  - Instantiated once with i_priority = pointer_next when in LOCKED, o_priority when in IDLE.
  - Its any-grant output is the registered-grant enable.
- This block holds all registers; the sub-module stays purely combinational.

## Test plan
- Reset and idle: reset_n low with i_request=4'b1111 (N=4, LAH=2). Required: o_grant=0, o_priority=4'b0001. After release of reset: o_grant=4'b0001 one cycle later, o_anyGnt=1, o_grant_idx=0.
- Lock hold: grant on requester 1, then raise requests 0, 2 and 3 for 5 cycles. Required: o_grant stays 4'b0010 and o_priority is unchanged.
- Round-robin fairness: i_request=4'b1111 held, release pulsed every cycle by the holder. Required grant sequence: 0001, 0010, 0100, 1000, 0001 with no idle cycle.
- Wrap and sole requester: holder 3 releases with i_request=4'b1000. Required: pointer becomes 4'b0001, o_grant=4'b1000 again next cycle. With i_request=4'b0000 instead: o_grant=0, state IDLE.
- Implicit release and ignored releases: holder 2 drops its request while i_request[0]=1. Required: o_grant=4'b0001 next cycle. Pulsing i_release[1] (a non-holder) changes nothing.
- Reset mid-transfer: assert reset_n low while LOCKED on requester 2. Required: outputs clear asynchronously within the same cycle and o_priority=4'b0001.
